// File: rtl/uart_rx.sv
// UART receive path: synchronizes RX_IN, majority-votes three mid-bit samples,
// shifts data in LSB first and checks optional parity plus the stop bit.
module uart_rx #(
  parameter int FRAME_WIDTH    = 8,
  parameter int PRESCALE_WIDTH = 6,
  parameter int BIT_CNT_WIDTH  = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      RX_IN,
  input  logic [PRESCALE_WIDTH-1:0] Prescale,
  input  logic                      PAR_EN,
  input  logic                      PAR_TYP,
  output logic [FRAME_WIDTH-1:0]    P_DATA,
  output logic                      data_valid,
  output logic                      par_err,
  output logic                      stp_err
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  localparam logic [PRESCALE_WIDTH-1:0] EDGE_ONE = PRESCALE_WIDTH'(1);
  localparam logic [PRESCALE_WIDTH-1:0] EDGE_TWO = PRESCALE_WIDTH'(2);
  localparam logic [BIT_CNT_WIDTH-1:0]  BIT_ONE  = BIT_CNT_WIDTH'(1);
  localparam logic [BIT_CNT_WIDTH-1:0]  BIT_LAST = BIT_CNT_WIDTH'(FRAME_WIDTH - 1);

  logic                      sync1_q;
  logic                      sync2_q;
  logic                      rx_s;

  logic [2:0]                state_q,    state_d;
  logic [PRESCALE_WIDTH-1:0] edge_cnt_q, edge_cnt_d;
  logic [BIT_CNT_WIDTH-1:0]  bit_cnt_q,  bit_cnt_d;
  logic [2:0]                samples_q,  samples_d;
  logic [FRAME_WIDTH-1:0]    shift_q,    shift_d;
  logic [PRESCALE_WIDTH-1:0] prescale_q, prescale_d;
  logic                      par_en_q,   par_en_d;
  logic                      par_typ_q,  par_typ_d;
  logic                      par_flag_q, par_flag_d;
  logic [FRAME_WIDTH-1:0]    p_data_q,   p_data_d;
  logic                      valid_q,    valid_d;
  logic                      par_err_q,  par_err_d;
  logic                      stp_err_q,  stp_err_d;

  logic [PRESCALE_WIDTH-1:0] half_pt;
  logic [PRESCALE_WIDTH-1:0] samp_first;
  logic [PRESCALE_WIDTH-1:0] samp_last;
  logic [PRESCALE_WIDTH-1:0] resolve_pt;
  logic [PRESCALE_WIDTH-1:0] last_edge;
  logic                      at_sample;
  logic                      at_resolve;
  logic                      at_wrap;
  logic                      bit_val;
  logic                      par_expected;

  // Synchronizer flops reset high so a reset never looks like a start bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= RX_IN;
      sync2_q <= sync1_q;
    end
  end

  assign rx_s = sync2_q;

  always_comb begin
    half_pt    = prescale_q >> 1;
    samp_first = half_pt - EDGE_ONE;
    samp_last  = half_pt + EDGE_ONE;
    resolve_pt = half_pt + EDGE_TWO;
    last_edge  = prescale_q - EDGE_ONE;
    at_sample  = (state_q != IDLE) &&
                 ((edge_cnt_q == samp_first) || (edge_cnt_q == half_pt) ||
                  (edge_cnt_q == samp_last));
    at_resolve = (state_q != IDLE) && (edge_cnt_q == resolve_pt);
    at_wrap    = (state_q != IDLE) && (edge_cnt_q == last_edge);
    bit_val    = (samples_q[0] & samples_q[1]) | (samples_q[0] & samples_q[2]) |
                 (samples_q[1] & samples_q[2]);
    par_expected = (^shift_q) ^ par_typ_q;
  end

  always_comb begin
    samples_d = samples_q;
    if (at_sample) begin
      samples_d = {samples_q[1:0], rx_s};
    end
  end

  // The frame ends at the stop-bit resolve point so a back-to-back start can follow.
  always_comb begin
    state_d    = state_q;
    edge_cnt_d = edge_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    prescale_d = prescale_q;
    par_en_d   = par_en_q;
    par_typ_d  = par_typ_q;
    par_flag_d = par_flag_q;
    p_data_d   = p_data_q;
    valid_d    = 1'b0;
    par_err_d  = 1'b0;
    stp_err_d  = 1'b0;

    if (state_q != IDLE) begin
      edge_cnt_d = at_wrap ? '0 : edge_cnt_q + EDGE_ONE;
    end

    case (state_q)
      IDLE: begin
        edge_cnt_d = '0;
        if (!rx_s) begin
          state_d    = START;
          edge_cnt_d = EDGE_ONE;
          bit_cnt_d  = '0;
          prescale_d = Prescale;
          par_en_d   = PAR_EN;
          par_typ_d  = PAR_TYP;
          par_flag_d = 1'b0;
        end
      end

      START: begin
        if (at_resolve && bit_val) begin
          state_d    = IDLE;
          edge_cnt_d = '0;
        end else if (at_wrap) begin
          state_d   = DATA;
          bit_cnt_d = '0;
        end
      end

      DATA: begin
        if (at_resolve) begin
          shift_d = {bit_val, shift_q[FRAME_WIDTH-1:1]};
        end
        if (at_wrap) begin
          if (bit_cnt_q == BIT_LAST) begin
            state_d = par_en_q ? PARITY : STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_ONE;
          end
        end
      end

      PARITY: begin
        if (at_resolve) begin
          par_flag_d = (bit_val != par_expected);
        end
        if (at_wrap) begin
          state_d = STOP;
        end
      end

      STOP: begin
        if (at_resolve) begin
          state_d    = IDLE;
          edge_cnt_d = '0;
          stp_err_d  = ~bit_val;
          par_err_d  = par_flag_q;
          if (bit_val && !par_flag_q) begin
            p_data_d = shift_q;
            valid_d  = 1'b1;
          end
        end
      end

      default: begin
        state_d    = IDLE;
        edge_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      edge_cnt_q <= '0;
      bit_cnt_q  <= '0;
      samples_q  <= '0;
      shift_q    <= '0;
      prescale_q <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      par_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      edge_cnt_q <= edge_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      samples_q  <= samples_d;
      shift_q    <= shift_d;
      prescale_q <= prescale_d;
      par_en_q   <= par_en_d;
      par_typ_q  <= par_typ_d;
      par_flag_q <= par_flag_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p_data_q  <= '0;
      valid_q   <= 1'b0;
      par_err_q <= 1'b0;
      stp_err_q <= 1'b0;
    end else begin
      p_data_q  <= p_data_d;
      valid_q   <= valid_d;
      par_err_q <= par_err_d;
      stp_err_q <= stp_err_d;
    end
  end

  assign P_DATA     = p_data_q;
  assign data_valid = valid_q;
  assign par_err    = par_err_q;
  assign stp_err    = stp_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: table-driven directed frames, hand-written
// corner sequences and random frames scored against a frame-level model.
module tb_uart_rx;

  localparam int W = 8;

  logic       clk = 1'b0;
  logic       resetN;
  logic       rxIn;
  logic [5:0] prescale;
  logic       parEn;
  logic       parTyp;
  logic [7:0] pData;
  logic       dataValid;
  logic       parErr;
  logic       stpErr;

  always #5 clk = ~clk;

  uart_rx dut (
    .clk        (clk),
    .reset      (resetN),
    .RX_IN      (rxIn),
    .Prescale   (prescale),
    .PAR_EN     (parEn),
    .PAR_TYP    (parTyp),
    .P_DATA     (pData),
    .data_valid (dataValid),
    .par_err    (parErr),
    .stp_err    (stpErr)
  );

  typedef struct {
    int         cyc;
    logic       dv;
    logic       pe;
    logic       se;
    logic [7:0] pdata;
  } event_t;

  typedef struct {
    logic [7:0] data;
    int         p;
    logic       pen;
    logic       ptyp;
    logic       flip;
    logic       stopBit;
    int         glitch;
    int         gap;
    logic       expDv;
    logic       expPe;
    logic       expSe;
    logic [7:0] expPdata;
  } vec_t;

  event_t     expQ[$];
  event_t     obsQ[$];
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  logic [7:0] lastGood = 8'h00;
  vec_t       vecs[7];

  always @(posedge clk) cyc <= cyc + 1;

  // Every cycle with any strobe high becomes one observed event.
  always @(negedge clk) begin
    if (dataValid || parErr || stpErr) begin
      event_t e;
      e.cyc   = cyc;
      e.dv    = dataValid;
      e.pe    = parErr;
      e.se    = stpErr;
      e.pdata = pData;
      obsQ.push_back(e);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drives one whole frame on the line, one line cycle per negedge; c0 is the
  // cycle the start bit first appears on the pin.
  task automatic sendFrame(input logic [7:0] data, input int p, input logic pen,
                           input logic ptyp, input logic flip, input logic stopBit,
                           input int glitchOff, input int gap, input bit scramble,
                           input int resetAt, input int releaseAt, output int c0);
    logic line[$];
    logic v;
    int   total;
    prescale = 6'(p);
    parEn    = pen;
    parTyp   = ptyp;
    c0       = 0;
    line.push_back(1'b0);
    for (int i = 0; i < W; i++) line.push_back(data[i]);
    if (pen) line.push_back((^data) ^ ptyp ^ flip);
    line.push_back(stopBit);
    total = line.size() * p;
    for (int k = 0; k < total + gap; k++) begin
      @(negedge clk);
      if (k == 0) c0 = cyc;
      v = (k < total) ? line[k / p] : 1'b1;
      if (k == glitchOff) v = ~v;
      rxIn = v;
      if (scramble && k == 3) begin
        prescale = 6'(8 << $urandom_range(0, 2));
        parEn    = 1'($urandom_range(0, 1));
        parTyp   = 1'($urandom_range(0, 1));
      end
      if (k == resetAt) begin
        resetN = 1'b0;
        #1;
        check("midResetPdata", pData, 8'h00);
        check("midResetStrobes", {dataValid, parErr, stpErr}, 3'b000);
      end
      if (k == releaseAt) resetN = 1'b1;
    end
  endtask

  function automatic int strobeCycle(input int c0, input int p, input logic pen);
    int n;
    n = 1 + W + int'(pen);
    return c0 + 2 + n * p + p / 2 + 3;
  endfunction

  task automatic applyStimulus(input vec_t v);
    int     c0;
    event_t e;
    sendFrame(v.data, v.p, v.pen, v.ptyp, v.flip, v.stopBit, v.glitch, v.gap,
              1'b0, -1, -1, c0);
    e.cyc   = strobeCycle(c0, v.p, v.pen);
    e.dv    = v.expDv;
    e.pe    = v.expPe;
    e.se    = v.expSe;
    e.pdata = v.expPdata;
    expQ.push_back(e);
    lastGood = v.expPdata;
  endtask

  task automatic checkOutput(input string name);
    int deadline;
    int nCmp;
    deadline = cyc + 40;
    if (expQ.size() > 0 && expQ[expQ.size()-1].cyc + 4 > deadline)
      deadline = expQ[expQ.size()-1].cyc + 4;
    while (cyc < deadline) @(negedge clk);
    check($sformatf("%s events", name), obsQ.size(), expQ.size());
    nCmp = (obsQ.size() < expQ.size()) ? obsQ.size() : expQ.size();
    for (int i = 0; i < nCmp; i++) begin
      check($sformatf("%s ev%0d cycle", name, i), obsQ[i].cyc, expQ[i].cyc);
      check($sformatf("%s ev%0d valid", name, i), obsQ[i].dv, expQ[i].dv);
      check($sformatf("%s ev%0d parErr", name, i), obsQ[i].pe, expQ[i].pe);
      check($sformatf("%s ev%0d stpErr", name, i), obsQ[i].se, expQ[i].se);
      check($sformatf("%s ev%0d pdata", name, i), obsQ[i].pdata, expQ[i].pdata);
    end
    check($sformatf("%s P_DATA", name), pData, lastGood);
    obsQ.delete();
    expQ.delete();
  endtask

  initial begin
    int         c0;
    logic [7:0] data;
    int         p;
    logic       pen, ptyp, flip, stopBit;
    int         n, glitch, gap;
    event_t     e;

    vecs[0] = '{8'hA5,  8, 1'b1, 1'b0, 1'b0, 1'b1, -1,  8, 1'b1, 1'b0, 1'b0, 8'hA5};
    vecs[1] = '{8'hA5,  8, 1'b1, 1'b0, 1'b1, 1'b1, -1,  8, 1'b0, 1'b1, 1'b0, 8'hA5};
    vecs[2] = '{8'h3C, 16, 1'b0, 1'b0, 1'b0, 1'b0, -1, 64, 1'b0, 1'b0, 1'b1, 8'hA5};
    vecs[3] = '{8'h55,  8, 1'b0, 1'b0, 1'b0, 1'b1, 28,  8, 1'b1, 1'b0, 1'b0, 8'h55};
    vecs[4] = '{8'h96, 16, 1'b1, 1'b0, 1'b1, 1'b0, -1, 64, 1'b0, 1'b1, 1'b1, 8'h55};
    vecs[5] = '{8'h01, 32, 1'b1, 1'b1, 1'b0, 1'b1, -1,  0, 1'b1, 1'b0, 1'b0, 8'h01};
    vecs[6] = '{8'hFE, 32, 1'b1, 1'b1, 1'b0, 1'b1, -1, 16, 1'b1, 1'b0, 1'b0, 8'hFE};

    resetN   = 1'b0;
    rxIn     = 1'b1;
    prescale = 6'd8;
    parEn    = 1'b0;
    parTyp   = 1'b0;
    repeat (3) @(negedge clk);
    check("resetPdata", pData, 8'h00);
    check("resetStrobes", {dataValid, parErr, stpErr}, 3'b000);
    resetN = 1'b1;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i]);
      if (vecs[i].gap != 0) checkOutput($sformatf("vec%0d", i));
    end

    // A 3-cycle low pulse at P=8 misses all three start samples.
    prescale = 6'd8;
    parEn    = 1'b0;
    repeat (3) begin
      @(negedge clk);
      rxIn = 1'b0;
    end
    @(negedge clk);
    rxIn = 1'b1;
    checkOutput("idleGlitch");

    // Reset lands in data bit 2 and is released once the rest of the line is high.
    sendFrame(8'hF0, 16, 1'b1, 1'b1, 1'b0, 1'b1, -1, 16, 1'b0, 3 * 16 + 5, 7 * 16 + 2, c0);
    lastGood = 8'h00;
    checkOutput("midFrameReset");

    applyStimulus('{8'h81, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1, 8, 1'b1, 1'b0, 1'b0, 8'h81});
    checkOutput("afterReset");

    for (int r = 0; r < 24; r++) begin
      data    = 8'($urandom);
      p       = 8 << $urandom_range(0, 2);
      pen     = 1'($urandom_range(0, 1));
      ptyp    = 1'($urandom_range(0, 1));
      flip    = ($urandom_range(0, 3) == 0);
      stopBit = ($urandom_range(0, 4) != 0);
      n       = 1 + W + int'(pen);
      glitch  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(p, n * p + p / 2 - 1)) : -1;
      if (!stopBit) gap = 80;
      else gap = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 20));
      sendFrame(data, p, pen, ptyp, flip, stopBit, glitch, gap, stopBit, -1, -1, c0);
      e.pe  = pen & flip;
      e.se  = ~stopBit;
      e.dv  = stopBit & ~e.pe;
      if (e.dv) lastGood = data;
      e.pdata = lastGood;
      e.cyc   = strobeCycle(c0, p, pen);
      expQ.push_back(e);
      if (gap != 0) checkOutput($sformatf("rand%0d", r));
    end
    checkOutput("final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receive path, the counterpart of the team's UART TX serializer/FSM.
- Oversamples the serial line at Prescale clocks per bit and detects the start bit.
- Majority-votes each bit, deserializes LSB-first data, and checks optional parity and the stop bit.
- Presents a parallel word with a one-cycle valid strobe, or a one-cycle error strobe. Sits between the pad-side RX line and the system-side consumer (register file / FIFO).

Parameters:
- FRAME_WIDTH, 8, number of data bits per frame.
- PRESCALE_WIDTH, 6, width of Prescale input and edge counter.
- BIT_CNT_WIDTH, 4, width of the data bit counter (must hold FRAME_WIDTH).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous active-low reset.
- RX_IN  input  1  serial line, idle high, asynchronous to clk.
- Prescale  input  PRESCALE_WIDTH  oversampling ratio; legal values 8, 16, 32.
- PAR_EN  input  1  1 = parity bit present after data.
- PAR_TYP  input  1  0 = even, 1 = odd parity.
- P_DATA  output  FRAME_WIDTH  last good received word.
- data_valid  output  1  one-cycle strobe, P_DATA updated and frame good.
- par_err  output  1  one-cycle strobe, parity mismatch.
- stp_err  output  1  one-cycle strobe, stop bit sampled 0.

Behaviour:
- Reset is asynchronous and active-low.
  - All state returns to IDLE; synchronizer flops go to 1.
  - P_DATA=0, data_valid=0, par_err=0, stp_err=0.
  - Reset mid-frame abandons the frame with no strobe.
- Input path: 2-flop synchronizer on RX_IN; all logic below uses the synchronized value rx_s (2-cycle latency from pin).
- Config latch: Prescale, PAR_EN and PAR_TYP are captured at start detection. Changes mid-frame take effect on the next frame. Prescale values other than 8, 16 or 32 are undefined.
- Cycle S: first cycle in IDLE with rx_s=0.
  - Latch config; go to START; edge_cnt <= 1 (cycle S counts as edge 0 of the start bit).
- Bit timing:
  - edge_cnt runs 0..P-1 within each bit, wraps to 0 and advances bit/state.
  - Samples are taken at edge_cnt = P/2-1, P/2, P/2+1.
  - Bit value = majority of the 3 samples, resolved at edge_cnt = P/2+2.
- States: IDLE -> START -> DATA -> [PARITY if PAR_EN] -> STOP -> IDLE.
- START:
  - Majority 0: continue to DATA at the wrap.
  - Majority 1 (glitch): return to IDLE at the resolve cycle, no strobe.
- DATA: FRAME_WIDTH bits shifted in LSB first; bit_cnt 0..FRAME_WIDTH-1; leave after the last bit wraps.
- PARITY:
  - Expected = XOR of data bits (PAR_TYP=0), or its inverse (PAR_TYP=1).
  - Mismatch is flagged for the end of frame.
- STOP: at resolve (edge_cnt=P/2+2) the frame ends; no wait for the stop-bit end, so back-to-back frames are tolerated.
  - Stop=1 and no parity error: P_DATA <= shift register; data_valid=1 for exactly one cycle.
  - Stop=0: stp_err=1 for one cycle.
  - Parity error: par_err=1 for one cycle.
  - Both errors may pulse together.
  - On any error, P_DATA holds its previous value and data_valid stays 0.
  - FSM returns to IDLE in the same cycle; a new start may be detected in the next cycle.
- Strobe timing: strobes are registered and high in cycle S + N*P + P/2 + 3.
  - N = 1 + FRAME_WIDTH + PAR_EN (stop-bit index).
  - Example: P=8, PAR_EN=1 gives N=10, strobe at S+87.
- rx_s held low continuously after a stop error: the frame ends, IDLE then immediately detects a new start (break handling is out of scope).
- Strobes are never high outside the single flagged cycle.

Test Plan:
- Good frame, parity on: Prescale=8, PAR_EN=1, PAR_TYP=0, send 0xA5 with parity bit 0 and stop 1 -> data_valid=1 for 1 cycle at S+87, P_DATA=0xA5, par_err=stp_err=0.
- Parity error: same frame with parity bit 1 -> par_err=1 for 1 cycle, data_valid=0, P_DATA unchanged (0xA5 from prior frame).
- Stop error and no parity: Prescale=16, PAR_EN=0, send 0x3C with stop bit 0 -> stp_err=1 at S+16*9+11=S+155, data_valid=0.
- Glitch and majority: 3-cycle low pulse on idle line at Prescale=8 -> no strobe, FSM in IDLE. A single-cycle inverted glitch at sample P/2 inside a data bit of 0x55 -> P_DATA=0x55 (majority wins).
- Back-to-back and mid-frame events:
  - Two frames 0x01, 0xFE at Prescale=32, odd parity, no idle gap -> two data_valid pulses with correct words.
  - Assert reset during DATA of a third frame -> all outputs 0 immediately, no strobe after release.
  - The next clean frame 0x81 is received correctly.
